// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding req/ack fetch, small in-order
// instruction buffer, valid/ready delivery to the core, redirect flush.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] O_INST,
    output logic [31:0] pc_out,
    output logic        inst_valid,
    input  logic        inst_ready
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DROP  = 1'b1
    } state_t;

    state_t             r_state;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_addr;
    logic               r_req;
    logic               r_valid;
    logic [31:0]        r_inst;
    logic [31:0]        r_pc;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_buf_inst [BUF_DEPTH];
    logic [31:0]        r_buf_pc   [BUF_DEPTH];

    logic [31:0]        w_redirect_pc;
    logic               w_hs;
    logic               w_push;
    logic               w_pop;
    logic               w_drop_n;
    logic [PTR_W-1:0]   w_rd_nxt;
    logic [CNT_W-1:0]   w_count_n;
    logic [31:0]        w_fetch_pc_n;
    logic               w_req_n;
    logic [31:0]        w_addr_n;
    logic [31:0]        w_head_inst_n;
    logic [31:0]        w_head_pc_n;

    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

    // Next-value logic; a redirect cancels this cycle's push and pop.
    always_comb begin
        w_hs          = r_req && imem_ack;
        w_push        = w_hs && (r_state == S_FETCH) && !redirect;
        w_pop         = r_valid && inst_ready && !redirect;
        w_drop_n      = r_req && !imem_ack && (redirect || (r_state == S_DROP));
        w_rd_nxt      = r_rd_ptr + PTR_W'(1);
        w_count_n     = r_count;
        w_fetch_pc_n  = r_fetch_pc;
        w_head_inst_n = r_inst;
        w_head_pc_n   = r_pc;

        if (redirect) begin
            w_count_n    = '0;
            w_fetch_pc_n = w_redirect_pc;
        end else begin
            w_count_n = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) begin
                w_fetch_pc_n = r_fetch_pc + 32'd4;
            end
        end

        // Requests are never abandoned, so a pending address survives a redirect.
        w_req_n  = w_drop_n || (w_count_n < CNT_W'(BUF_DEPTH));
        w_addr_n = w_drop_n ? r_addr : w_fetch_pc_n;

        // Head register tracks the entry that will sit at the FIFO head after this edge.
        if (!redirect) begin
            if (w_pop && (r_count > CNT_W'(1))) begin
                w_head_inst_n = r_buf_inst[w_rd_nxt];
                w_head_pc_n   = r_buf_pc[w_rd_nxt];
            end else if (w_push && ((r_count == '0) || (w_pop && (r_count == CNT_W'(1))))) begin
                w_head_inst_n = imem_rdata;
                w_head_pc_n   = r_fetch_pc;
            end
        end
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_inst     <= '0;
            r_pc       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_drop_n ? S_DROP : S_FETCH;
            r_fetch_pc <= w_fetch_pc_n;
            r_addr     <= w_addr_n;
            r_req      <= w_req_n;
            r_valid    <= (w_count_n != '0);
            r_inst     <= w_head_inst_n;
            r_pc       <= w_head_pc_n;
            r_count    <= w_count_n;
            if (redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= w_rd_nxt;
            end
        end
    end

    // Buffer storage carries no reset; only count/pointers define occupancy.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_buf_inst[r_wr_ptr] <= imem_rdata;
            r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign O_INST     = r_inst;
    assign pc_out     = r_pc;
    assign inst_valid = r_valid;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of the single-cycle MIPS core (DataPath + ControlUnit). Holds the fetch PC, issues one word-aligned request at a time to an instruction memory with a req/ack handshake, and buffers returned words in a small FIFO. Presents instructions and their PCs to the core over a valid/ready handshake. Accepts branch/jump redirects that flush buffered and in-flight instructions.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, instruction buffer entries; power of two, >= 2.
- clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- imem_req  out  1  request valid; held with stable imem_addr until acknowledged.
- imem_addr  out  32  word address of current request, bits [1:0] = 0.
- imem_ack  in  1  memory accepts request and returns imem_rdata in the same cycle; sampled only while imem_req = 1.
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ack.
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 0.
- O_INST  out  32  instruction at FIFO head; drives the core's instruction input.
- pc_out  out  32  PC of O_INST.
- inst_valid  out  1  FIFO non-empty.
- inst_ready  in  1  core consumes head when inst_valid && inst_ready.

## Operation
- State machine: FETCH, DROP.
  - FETCH: imem_req = (count < BUF_DEPTH). On req && ack: push {fetch_pc, imem_rdata}; fetch_pc <= fetch_pc + 4.
  - DROP: entered on redirect while a request is pending (imem_req = 1, no ack in that cycle). imem_req stays high, imem_addr holds the old address, and the response is discarded on ack. Next state is FETCH, now at redirect_pc.
- Requests cannot be aborted. The address is never changed while imem_req = 1 and no ack has been received.
- Redirect, in any state:
  - FIFO count <= 0; any push or pop in that cycle is cancelled.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - If redirect coincides with an ack in FETCH, that word is discarded and the state stays FETCH.
  - A redirect while in DROP updates the target and stays in DROP.
- FIFO:
  - Circular read/write pointers of width log2(BUF_DEPTH), plus a count of width log2(BUF_DEPTH)+1.
  - Simultaneous push and pop keeps count unchanged.
  - No push when full: guaranteed because req is gated by count < BUF_DEPTH.
  - Pop only when inst_valid; inst_ready while empty is ignored.
- Arithmetic: fetch_pc + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- O_INST / pc_out reflect the head entry and are held stable while inst_valid && !inst_ready. When empty, they hold their last value (don't-care for the consumer).

## Timing
- Reset (Reset = 1 at an edge) sets:
  - state FETCH, fetch_pc = RESET_PC, count 0.
  - inst_valid 0, O_INST 0, pc_out 0, imem_req 0 for the reset cycle.
- First cycle after Reset deasserts: imem_req = 1, imem_addr = RESET_PC.
- Reset asserted mid-request drops the request (imem_req low next cycle). The memory must tolerate an abandoned request on reset only.
- Latency: an ack at edge N makes the word visible on O_INST with inst_valid = 1 after edge N; no combinational path from imem_rdata to O_INST.
- Throughput: zero-wait memory (ack tied high) plus a consumer that is always ready sustains one instruction per cycle from cycle 2 after reset.
- Redirect at edge N: inst_valid = 0 after N.
  - From FETCH: first request to the new PC issues in cycle N+1.
  - From DROP: the new request issues the cycle after the discarded ack.
- imem_req depends only on registered state: no combinational path from inst_ready, imem_ack or redirect to imem_req/imem_addr.

## Test plan
- Reset, ack tied 1, inst_ready 1, memory returns addr^32'hA5A5_0000 -> inst_valid from cycle 2; pc_out 0,4,8,... one per cycle; O_INST matches.
- inst_ready held 0 for 6 cycles -> exactly BUF_DEPTH = 2 acks; imem_req drops; O_INST holds 0x…0000; release returns in order with no loss or duplication.
- Ack delayed 3 cycles per request -> imem_addr stable during the wait; one instruction per 4 cycles; order preserved.
- Redirect to 32'h0000_0100 during a pending request with 2-cycle ack delay -> stale word dropped; first valid pc_out = 0x100; flushed entries never appear.
- Redirect coincident with ack and pop; redirect_pc = 32'h0000_0203 -> no push/pop; next imem_addr = 0x200.
- Redirect to 32'hFFFF_FFF8 -> pc_out FFFF_FFF8, FFFF_FFFC, 0000_0000; Reset asserted mid-stream -> imem_req 0, inst_valid 0 next cycle, restart at RESET_PC.
